// File: rtl/ps2_mouse_tracker_pkg.sv
// rtl/ps2_mouse_tracker_pkg.sv - shared packet bit positions, FSM states and axis helpers
package ps2_mouse_tracker_pkg;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_TIMEOUT  = 100000;

  localparam int PKT_LEFT  = 0;
  localparam int PKT_RIGHT = 1;
  localparam int PKT_SYNC  = 3;
  localparam int PKT_XSIGN = 4;
  localparam int PKT_YSIGN = 5;
  localparam int PKT_XOVF  = 6;
  localparam int PKT_YOVF  = 7;

  typedef enum logic [1:0] {
    ST_BYTE0 = 2'd0,
    ST_BYTE1 = 2'd1,
    ST_BYTE2 = 2'd2
  } pkt_state_e;

  // 9-bit two's complement delta widened to 12 bits; an overflowed axis contributes nothing
  function automatic logic signed [11:0] axis_delta(input logic sign, input logic [7:0] mag,
                                                   input logic ovf);
    return ovf ? 12'sd0 : $signed({{4{sign}}, mag});
  endfunction

  function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input logic [9:0] hi);
    if (v[11]) return 10'd0;
    else if (v > $signed({2'b00, hi})) return hi;
    else return v[9:0];
  endfunction

endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// rtl/ps2_mouse_tracker_if.sv - raw PS/2 lines in, cursor/button bus out
interface ps2_mouse_tracker_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [9:0] mouseX;
  logic [9:0] mouseY;
  logic       mouseLeftButton;
  logic       mouseRightButton;
  logic       packetValid;
  logic       frameError;

  modport master (
    input  ps2Clk, ps2Data,
    output mouseX, mouseY, mouseLeftButton, mouseRightButton, packetValid, frameError
  );

  modport slave (
    output ps2Clk, ps2Data,
    input  mouseX, mouseY, mouseLeftButton, mouseRightButton, packetValid, frameError
  );
endinterface

// File: rtl/ps2_mouse_tracker_rx.sv
// rtl/ps2_mouse_tracker_rx.sv - PS/2 byte receiver: synchronisers, 11-bit framing, idle resync
module ps2_mouse_tracker_rx #(
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rxByte,
  output logic       rxValid,
  output logic       rxError,
  output logic       rxTimeout
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   shift_q, shift_d;
  logic          done_q, done_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          fall;
  logic          frame_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 11'd0;
      done_q      <= 1'b0;
      idle_q      <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q[1];

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    clk_prev_d  = clk_sync_q[1];
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    idle_d      = idle_q;
    rxTimeout   = 1'b0;
    if (fall) begin
      idle_d  = '0;
      shift_d = {data_sync_q[1], shift_q[10:1]};
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        done_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (idle_q == IDLE_LAST) begin
      // Counter parks at TIMEOUT so the resync fires once per idle period
      idle_d    = IDLE_MAX;
      bit_cnt_d = 4'd0;
      rxTimeout = 1'b1;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // shift_q holds {stop, parity, d[7:0], start} once the 11th bit is in
  assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
  assign rxByte   = shift_q[8:1];
  assign rxValid  = done_q & frame_ok;
  assign rxError  = done_q & ~frame_ok;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// rtl/ps2_mouse_tracker.sv - 3-byte PS/2 mouse packet decoder with clamped absolute cursor
module ps2_mouse_tracker
  import ps2_mouse_tracker_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                 clk,
  input logic                 reset,
  ps2_mouse_tracker_if.master bus
);

  localparam logic [9:0] X_MAX  = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX  = 10'(SCREEN_H - 1);
  localparam logic [9:0] X_INIT = 10'(SCREEN_W / 2);
  localparam logic [9:0] Y_INIT = 10'(SCREEN_H / 2);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_error, rx_timeout;

  pkt_state_e        state_q, state_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              left_q, left_d, right_q, right_d;
  logic              pv_q, pv_d, fe_q, fe_d;
  logic signed [11:0] nx, ny;

  ps2_mouse_tracker_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (bus.ps2Clk),
    .ps2_data (bus.ps2Data),
    .rxByte   (rx_byte),
    .rxValid  (rx_valid),
    .rxError  (rx_error),
    .rxTimeout(rx_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BYTE0;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      x_q     <= X_INIT;
      y_q     <= Y_INIT;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      left_q  <= left_d;
      right_q <= right_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
    end
  end

  // Screen Y grows downward while PS/2 +dy means up, hence the subtraction
  assign nx = $signed({2'b00, x_q}) + axis_delta(b0_q[PKT_XSIGN], b1_q, b0_q[PKT_XOVF]);
  assign ny = $signed({2'b00, y_q}) - axis_delta(b0_q[PKT_YSIGN], rx_byte, b0_q[PKT_YOVF]);

  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    right_d = right_q;
    pv_d    = 1'b0;
    fe_d    = 1'b0;
    if (rx_timeout) begin
      state_d = ST_BYTE0;
    end else if (rx_error) begin
      state_d = ST_BYTE0;
      fe_d    = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_BYTE0: begin
          if (rx_byte[PKT_SYNC]) begin
            b0_d    = rx_byte;
            state_d = ST_BYTE1;
          end
        end
        ST_BYTE1: begin
          b1_d    = rx_byte;
          state_d = ST_BYTE2;
        end
        ST_BYTE2: begin
          x_d     = clamp_axis(nx, X_MAX);
          y_d     = clamp_axis(ny, Y_MAX);
          left_d  = b0_q[PKT_LEFT];
          right_d = b0_q[PKT_RIGHT];
          pv_d    = 1'b1;
          state_d = ST_BYTE0;
        end
        default: state_d = ST_BYTE0;
      endcase
    end
  end

  assign bus.mouseX           = x_q;
  assign bus.mouseY           = y_q;
  assign bus.mouseLeftButton  = left_q;
  assign bus.mouseRightButton = right_q;
  assign bus.packetValid      = pv_q;
  assign bus.frameError       = fe_q;

endmodule
